// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: serialises data (priority) and instruction accesses,
// pulses ihit/dhit on completion and latches a sticky error if the RAM never answers.
module memory_arbiter #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              ihit,
    output logic              dhit,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              mem_err
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DREQ,
        ST_IREQ,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic              wr_reg, wr_next;
    logic              src_d_reg, src_d_next;
    logic [WORD_W-1:0] ramaddr_reg, ramaddr_next;
    logic [WORD_W-1:0] ramstore_reg, ramstore_next;
    logic [WORD_W-1:0] iload_reg, iload_next;
    logic [WORD_W-1:0] dload_reg, dload_next;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            wr_reg       <= 1'b0;
            src_d_reg    <= 1'b0;
            ramaddr_reg  <= '0;
            ramstore_reg <= '0;
            iload_reg    <= '0;
            dload_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            wr_reg       <= wr_next;
            src_d_reg    <= src_d_next;
            ramaddr_reg  <= ramaddr_next;
            ramstore_reg <= ramstore_next;
            iload_reg    <= iload_next;
            dload_reg    <= dload_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        wr_next       = wr_reg;
        src_d_next    = src_d_reg;
        ramaddr_next  = ramaddr_reg;
        ramstore_next = ramstore_reg;
        iload_next    = iload_reg;
        dload_next    = dload_reg;
        ramREN        = 1'b0;
        ramWEN        = 1'b0;
        ihit          = 1'b0;
        dhit          = 1'b0;
        mem_err       = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                // Data wins over instruction; a write wins over a read.
                if (dREN || dWEN) begin
                    state_next    = ST_DREQ;
                    src_d_next    = 1'b1;
                    wr_next       = dWEN;
                    ramaddr_next  = daddr;
                    ramstore_next = dstore;
                    wait_cnt_next = '0;
                end else if (iREN) begin
                    state_next    = ST_IREQ;
                    src_d_next    = 1'b0;
                    wr_next       = 1'b0;
                    ramaddr_next  = iaddr;
                    ramstore_next = dstore;
                    wait_cnt_next = '0;
                end
            end
            ST_DREQ, ST_IREQ: begin
                ramREN = !wr_reg;
                ramWEN = wr_reg;
                if (ram_ready) begin
                    state_next = ST_DONE;
                    if (!wr_reg) begin
                        if (src_d_reg) dload_next = ramload;
                        else           iload_next = ramload;
                    end
                end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    state_next = ST_ERR;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Hit only if the requester is still waiting; never re-grant here.
                ihit          = !src_d_reg && iREN;
                dhit          = src_d_reg && (dREN || dWEN);
                wait_cnt_next = '0;
                state_next    = ST_IDLE;
            end
            ST_ERR: begin
                mem_err = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign iload    = iload_reg;
    assign dload    = dload_reg;
    assign ramaddr  = ramaddr_reg;
    assign ramstore = ramstore_reg;

endmodule
